// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between the fetch and data ports.
// Data access goes first; the CPU is stalled until both have completed.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wrdata,
    input  logic [3:0]  d_wrstb,
    output logic [31:0] d_rddata,
    output logic        stall,
    output logic        done,
    output logic        bus_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic [3:0]  mem_wrstb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rddata
);

    typedef enum logic [1:0] {
        IDLE,
        D_WAIT,
        I_WAIT,
        DONE
    } state_t;

    // The last permitted wait cycle is the one whose un-acked end would
    // bring the counter to the limit; an ack in that cycle still wins.
    localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic        in_wait;
    logic        abort;
    logic        fin;
    logic [31:0] rd_val;

    assign in_wait = (state == D_WAIT) || (state == I_WAIT);
    assign abort   = in_wait && !mem_ack && (cnt == LIMIT_M1);
    assign fin     = in_wait && (mem_ack || abort);
    assign rd_val  = mem_ack ? mem_rddata : ERR_DATA;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Wait counter: zero on entry to each wait state, counts un-acked cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (!in_wait || fin) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Result buffers: written only when their own access finishes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_rddata <= 32'd0;
            i_data   <= 32'd0;
        end else if (fin) begin
            if (state == D_WAIT) begin
                d_rddata <= rd_val;
            end else begin
                i_data <= rd_val;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (abort) begin
            bus_err <= 1'b1;
        end
    end

    // Next-state and bus/handshake outputs.
    always_comb begin
        state_nx   = state;
        stall      = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = 32'd0;
        mem_wrdata = 32'd0;
        mem_wrstb  = 4'd0;
        unique case (state)
            IDLE: begin
                stall = i_req | d_req;
                if (d_req) begin
                    state_nx = D_WAIT;
                end else if (i_req) begin
                    state_nx = I_WAIT;
                end
            end
            D_WAIT: begin
                stall      = 1'b1;
                mem_req    = 1'b1;
                mem_addr   = d_addr;
                mem_wrdata = d_wrdata;
                mem_wrstb  = d_wrstb;
                if (fin) begin
                    state_nx = i_req ? I_WAIT : DONE;
                end
            end
            I_WAIT: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = i_addr;
                if (fin) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory bus between the CPU's instruction-fetch port and data port.
- Sequences at most one data access and one fetch per CPU cycle over the shared bus. The data access goes first, because it belongs to the older instruction.
- Holds the CPU pipeline with `stall` until both accesses complete, then presents the buffered results for exactly one cycle.
- Sits between the CPU core's IMEM/DMEM interfaces and the external memory controller.

Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum number of wait cycles per bus access before it is aborted and flagged. Legal range 1..255.
- `ERR_DATA`, default 32'h0000_0000: read data returned for an aborted access.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `i_req` input 1: the CPU requests an instruction fetch this cycle.
- `i_addr` input 32: fetch address.
- `i_data` output 32: fetched instruction; valid when `done` is 1.
- `d_req` input 1: the CPU requests a data access this cycle.
- `d_addr` input 32: data address.
- `d_wrdata` input 32: store data.
- `d_wrstb` input 4: byte write strobes; 0 means read.
- `d_rddata` output 32: load data; valid when `done` is 1.
- `stall` output 1: the CPU must hold all pipeline registers and keep its request inputs stable.
- `done` output 1: single-cycle pulse; buffered results are valid.
- `bus_err` output 1: sticky timeout flag.
- `mem_req` output 1: bus access request.
- `mem_addr` output 32: bus address.
- `mem_wrdata` output 32: bus write data.
- `mem_wrstb` output 4: bus write strobes.
- `mem_ack` input 1: the bus access completes this cycle.
- `mem_rddata` input 32: bus read data; valid when `mem_ack` is 1.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low on `rst_n`.
- Reset values:
  - State IDLE.
  - `i_data`, `d_rddata` buffers = 0.
  - `bus_err` = 0; timeout counter = 0.
  - `done` = 0; `mem_req` = 0; `mem_wrstb` = 0.
  - `stall` = `i_req` | `d_req`, combinational in IDLE.
- States: IDLE, D_WAIT, I_WAIT, DONE.
- IDLE:
  - If `d_req`, go to D_WAIT.
  - Else if `i_req`, go to I_WAIT.
  - Else stay.
  - `stall` = `i_req` | `d_req`.
- D_WAIT:
  - Outputs: `mem_req` = 1, `mem_addr` = `d_addr`, `mem_wrdata` = `d_wrdata`, `mem_wrstb` = `d_wrstb`.
  - On `mem_ack`: latch `mem_rddata` into `d_rddata`. Go to I_WAIT if `i_req`, else DONE.
  - `stall` = 1.
- I_WAIT:
  - Outputs: `mem_req` = 1, `mem_addr` = `i_addr`, `mem_wrstb` = 0, `mem_wrdata` = 0.
  - On `mem_ack`: latch `mem_rddata` into `i_data`; go to DONE.
  - `stall` = 1.
- DONE:
  - `done` = 1, `stall` = 0, `mem_req` = 0.
  - Unconditionally go to IDLE next cycle. New requests are sampled in IDLE, never in DONE.
- Latency: with zero-wait memory (`mem_ack` in the first cycle of `mem_req`):
  - Both requests: `stall` high for 3 cycles, `done` in the 4th.
  - One request: `stall` high for 2 cycles, `done` in the 3rd.
- `mem_req` comes only from state: it is never asserted in IDLE or DONE.
- Bus outputs are 0 when `mem_req` = 0.
- Timeout:
  - The counter clears on entry to each wait state and increments every wait cycle without `mem_ack`.
  - When it reaches `TIMEOUT_CYCLES` with no ack, the access aborts: the buffer gets `ERR_DATA`, `bus_err` sets, and the FSM advances exactly as if acked.
  - `mem_ack` in the same cycle as the limit counts as a normal ack: no error, real data.
  - `bus_err` clears only on reset.
- Buffers hold their value between transactions. A request type that was not issued leaves its buffer unchanged.
- `mem_ack` in IDLE or DONE is ignored.
- Reset mid-access: the next edge with `rst_n` = 0 forces IDLE and drops `mem_req` immediately. No partial latch into the buffers.
- Requests dropped while stalled are a CPU protocol violation. The behaviour is undefined; the testbench asserts `i_req`/`d_req`/addresses are stable while `stall` = 1.

Test Plan:
- Zero-wait load + fetch:
  - Stimulus: `d_req` = 1, `d_addr` = 0x100, `d_wrstb` = 0, `i_req` = 1, `i_addr` = 0x40; memory acks immediately with 0xAAAA0001 then 0xBBBB0002.
  - Required: `mem_addr` sequence 0x100, 0x40; `done` pulses in cycle 4; `d_rddata` = 0xAAAA0001, `i_data` = 0xBBBB0002; `stall` high exactly cycles 1-3.
- Store with wait states:
  - Stimulus: `d_wrstb` = 4'b0011, `d_wrdata` = 0x12345678, `d_addr` = 0x200; ack after 3 wait cycles; `i_req` = 0.
  - Required: `mem_wrstb` = 0011 held for 4 cycles, then DONE; `i_data` unchanged; `bus_err` = 0.
- Fetch only:
  - Stimulus: `i_req` = 1, `i_addr` = 0x8; immediate ack with 0xCAFEF00D.
  - Required: `done` in cycle 3; `i_data` = 0xCAFEF00D; `mem_wrstb` always 0.
- Timeout with `TIMEOUT_CYCLES` = 4:
  - Stimulus: `d_req` read, no ack.
  - Required: abort after 4 wait cycles; `d_rddata` = `ERR_DATA`; `bus_err` = 1 and remains 1 across later good transactions until reset.
- Boundary, ack on limit: ack arrives in the same cycle the counter hits the limit -> real data latched, `bus_err` stays 0.
- Reset in D_WAIT:
  - Stimulus: `rst_n` = 0 for one edge during D_WAIT.
  - Required: state IDLE, `mem_req` = 0, `bus_err` = 0, buffers = 0 on the next cycle.
- Idle bus: no requests for 10 cycles -> `stall` = 0, `mem_req` = 0, `done` = 0 throughout; `mem_ack` pulses ignored.
